toggle_event_counter: RTL

- Downstream consumer of a T flip-flop's q output.
- Treats each level change on tog_in as one event and emits a one-cycle evt_pulse per event.
- Accumulates events in a saturating counter.
- Hands out count snapshots over a 4-phase req/ack readout; each snapshot clears the counter for the next window.

---
 rtl/toggle_evt_pkg.sv | 13 +
 rtl/toggle_edge_det.sv | 46 ++++
 rtl/toggle_event_counter.sv | 92 +++++++++
 3 files changed

// File: rtl/toggle_evt_pkg.sv
// Shared types and defaults for the toggle event counter: readout FSM encoding
// and the default counter width.
package toggle_evt_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/toggle_edge_det.sv
// Level-change detector for a toggle line. Defining TOGGLE_EVT_SYNC_EN inserts
// a 2-flop synchronizer in front of the detector for an asynchronous tog_in.
module toggle_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic evt
);

  logic       tog_s;
  logic       tog_d;
  logic [1:0] prime_cnt;
  logic       primed;

`ifdef TOGGLE_EVT_SYNC_EN
  // Arm only once the synchronizer carries the first real sample, so a level
  // held from reset release is taken as the baseline rather than an event.
  localparam logic [1:0] PRIME_EDGES = 2'd3;
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], tog_in};
  end

  assign tog_s = sync_q[1];
`else
  localparam logic [1:0] PRIME_EDGES = 2'd1;
  assign tog_s = tog_in;
`endif

  assign primed = (prime_cnt == PRIME_EDGES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_d     <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      tog_d <= tog_s;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign evt = primed & (tog_s ^ tog_d);

endmodule

// File: rtl/toggle_event_counter.sv
// Counts level changes on a toggle line in a saturating counter and hands out
// count snapshots over a 4-phase req/ack readout. Option: TOGGLE_EVT_SYNC_EN.
module toggle_event_counter
  import toggle_evt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             evt_pulse,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_ovf,
  output logic [CNT_W-1:0] cnt_live
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             evt;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             capt;
  rd_state_t        state_q;
  rd_state_t        state_d;

  toggle_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .tog_in (tog_in),
    .evt    (evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) evt_pulse <= 1'b0;
    else      evt_pulse <= evt;
  end

  // An event during the capture cycle opens the new window instead of
  // landing in the snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (capt) begin
      cnt <= evt ? CNT_ONE : '0;
      ovf <= 1'b0;
    end else if (evt) begin
      if (cnt == CNT_MAX) ovf <= 1'b1;
      cnt <= sat_inc(cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else if (capt) begin
      rd_data <= cnt;
      rd_ovf  <= ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_req) state_d = CAPT;
      CAPT:    state_d = ACK;
      ACK:     if (!rd_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capt   = (state_q == CAPT);
    rd_ack = (state_q == ACK);
  end

  assign cnt_live = cnt;

endmodule
